// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/shift ops plus a 32-step shift-add multiplier.
// Define ALU_EXEC_UNIT_FAST_MUL_EN to replace the iterative multiplier with a combinational one.
module alu_exec_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        zero_o
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    logic [4:0]  shamt;
    logic [31:0] alu_res;

    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        valid_q, valid_d;

    assign shamt = data2_i[4:0];

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:          alu_res = data1_i & data2_i;
            OP_XOR:          alu_res = data1_i ^ data2_i;
            OP_SLL:          alu_res = data1_i << shamt;
            OP_ADD, OP_ADDI: alu_res = data1_i + data2_i;
            OP_SUB:          alu_res = data1_i - data2_i;
`ifdef ALU_EXEC_UNIT_FAST_MUL_EN
            OP_MUL:          alu_res = data1_i * data2_i;
`else
            OP_MUL:          alu_res = '0;
`endif
            OP_SRAI:         alu_res = $unsigned($signed(data1_i) >>> shamt);
            default:         alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_UNIT_FAST_MUL_EN

    // Every op, mul included, retires on the accepting edge.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (start_i) begin
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign busy_o = 1'b0;

`else

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_step;

    // Accumulator value after this edge's iteration; also the final product on count 31.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ctrl_i == OP_MUL) begin
                        mcand_d  = data1_i;
                        mplier_d = data2_i;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == 32'd0);
                        valid_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == 32'd0);
                    valid_d  = 1'b1;
                    count_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign busy_o = (state_q == S_MUL);

`endif

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with immediate-assertion checks.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  ctrl = 3'b000;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        busy, valid, zero;
    logic [31:0] result;

    int ncmp = 0;
    int nfail = 0;

    alu_exec_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
        .data1_i(d1), .data2_i(d2), .busy_o(busy), .valid_o(valid),
        .result_o(result), .zero_o(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; expect valid/result after the accepting edge, pulse gone one cycle later.
    task automatic op1(input string tag, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1; ctrl = c; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check(tag, result, exp);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        @(posedge clk); #1;
        check({tag, " pulse"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
`ifdef ALU_EXEC_UNIT_FAST_MUL_EN
        op1(tag, 3'b101, a, b, exp);
`else
        int n;
        int nv;
        n = 0;
        nv = 0;
        @(negedge clk);
        start = 1'b1; ctrl = 3'b101; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        while (busy && n < 40) begin
            // Requests arriving while busy must be dropped.
            if (n >= 3 && n <= 6) begin
                start = 1'b1; ctrl = 3'b011; d1 = 32'd100; d2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (valid) nv++;
        end
        start = 1'b0;
        check({tag, " busy cycles"}, n, 32'd32);
        check({tag, " valid count"}, nv, 32'd1);
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check(tag, result, exp);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        @(posedge clk); #1;
        check({tag, " pulse"}, {31'd0, valid}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Mid-cycle reset from power-up.
        #3 rst = 1'b1;
        #1;
        check("rst result", result, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd1);
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;

        op1("and", 3'b000, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0000);
        op1("xor", 3'b001, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF);
        op1("add", 3'b011, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF);
        op1("sub", 3'b100, 32'h0000_00F0, 32'h0000_0F0F, 32'hFFFF_F1E1);

        // Asynchronous reset clears a held nonzero result without waiting for a clock.
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("midrst result", result, 32'd0);
        check("midrst zero", {31'd0, zero}, 32'd1);
        @(negedge clk) rst = 1'b0;

        op1("sll", 3'b010, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008);
        op1("srai", 3'b111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
        op1("addi wrap", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        op1("add wrap", 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);

        // Back-to-back single-cycle requests: one valid per request, consecutive cycles.
        @(negedge clk);
        start = 1'b1; ctrl = 3'b001; d1 = 32'h0000_00F0; d2 = 32'h0000_0F0F;
        @(posedge clk); #1;
        check("b2b1 valid", {31'd0, valid}, 32'd1);
        check("b2b1", result, 32'h0000_0FFF);
        ctrl = 3'b000; d1 = 32'h0000_FF00; d2 = 32'h0000_0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b2 valid", {31'd0, valid}, 32'd1);
        check("b2b2", result, 32'h0000_0F00);
        @(posedge clk); #1;
        check("b2b pulse", {31'd0, valid}, 32'd0);

        do_mul("mul", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        do_mul("mul wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

`ifndef ALU_EXEC_UNIT_FAST_MUL_EN
        // Abort a mul after 10 cycles; no valid may escape, result drops to 0.
        begin
            int nv;
            nv = 0;
            @(negedge clk);
            start = 1'b1; ctrl = 3'b101; d1 = 32'd7; d2 = 32'd9;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) begin
                @(posedge clk); #1;
                if (valid) nv++;
            end
            #2 rst = 1'b1;
            #1;
            check("abort valid seen", nv, 32'd0);
            check("abort result", result, 32'd0);
            check("abort zero", {31'd0, zero}, 32'd1);
            check("abort busy", {31'd0, busy}, 32'd0);
            check("abort valid", {31'd0, valid}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            start = 1'b1; ctrl = 3'b011; d1 = 32'd2; d2 = 32'd3;
            @(posedge clk); #1;
            start = 1'b0;
            check("post-abort valid", {31'd0, valid}, 32'd1);
            check("post-abort add", result, 32'd5);
            @(posedge clk); #1;
            check("post-abort pulse", {31'd0, valid}, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
